// File: rtl/counter_checker.sv
// counter_checker: predicts 4-bit multi-mode counter outputs one edge behind the stimulus and pulses err_* on any checked mismatch
module counter_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             load,
  input  logic             rco,
  output logic             err,
  output logic             err_q,
  output logic             err_load,
  output logic             err_rco,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic             synced
);
  typedef enum logic {UNSYNC, SYNC} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state, next;
  logic [WIDTH-1:0] exp_q, nxt_q;
  logic exp_load, exp_rco, chk_q, chk_load, chk_rco;
  logic nxt_load, nxt_rco, nxt_chk_q, nxt_chk_rco;
  logic m_q, m_load, m_rco, m_any;
  always_ff @(posedge clk) state <= reset ? SYNC : next;
  always_comb next = !enable ? UNSYNC : mode == 2'b11 ? SYNC : state;
  always_comb synced = state == SYNC;
  always_comb begin
    nxt_q = mode == 2'b00 ? exp_q + WIDTH'(3) :
            mode == 2'b01 ? exp_q - WIDTH'(1) :
            mode == 2'b10 ? exp_q + WIDTH'(1) : D;
    nxt_load = enable && mode == 2'b11;
    nxt_rco = enable && (mode == 2'b00 ? exp_q >= MAX - WIDTH'(2) : exp_q == MAX);
    nxt_chk_q = enable && (state == SYNC || mode == 2'b11);
    nxt_chk_rco = !enable || state == SYNC;
  end
  always_comb begin
    m_q = chk_q;
    m_load = chk_load;
    m_rco = chk_rco;
    if (Q == exp_q) m_q = 1'b0;
    if (load == exp_load) m_load = 1'b0;
    if (rco == exp_rco) m_rco = 1'b0;
    m_any = m_q | m_load | m_rco;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      exp_load <= 1'b0;
      exp_rco <= 1'b0;
      chk_q <= 1'b1;
      chk_load <= 1'b1;
      chk_rco <= 1'b1;
      err <= 1'b0;
      err_q <= 1'b0;
      err_load <= 1'b0;
      err_rco <= 1'b0;
      err_sticky <= 1'b0;
      err_count <= '0;
    end else begin
      exp_q <= nxt_q;
      exp_load <= nxt_load;
      exp_rco <= nxt_rco;
      chk_q <= nxt_chk_q;
      chk_load <= 1'b1;
      chk_rco <= nxt_chk_rco;
      err <= m_any;
      err_q <= m_q;
      err_load <= m_load;
      err_rco <= m_rco;
      err_sticky <= err_sticky | m_any;
      err_count <= (m_any && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
    end
  end
endmodule
